// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: successive-approximation initiator for a magnitude comparator.
// Probes MSB first; each trial is held CMP_LAT extra cycles before its flags are sampled.
module sar_search_ctrl #(
    parameter int WIDTH   = 4,
    parameter int CMP_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             a_gt_b,
    input  logic             a_lt_b,
    input  logic             a_eq_b,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;
    localparam logic [IW-1:0]    MSB_IDX = IW'(WIDTH - 1);
    localparam logic [CW-1:0]    LAT     = CW'(CMP_LAT);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROBE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_trial;
    logic [WIDTH-1:0] r_result;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_wait;
    logic             r_found;
    logic             r_err;

    logic             w_start;
    logic             w_sample;
    logic             w_onehot;
    logic             w_last;
    logic [WIDTH-1:0] w_bit;
    logic [WIDTH-1:0] w_kept;
    logic [WIDTH-1:0] w_upd;

    // abort beats start; start is only honoured outside PROBE
    assign w_start  = start & ~abort & (r_state != S_PROBE);
    assign w_sample = (r_state == S_PROBE) & ~abort & (r_wait == '0);
    assign w_onehot = ({a_gt_b, a_lt_b, a_eq_b} == 3'b100) |
                      ({a_gt_b, a_lt_b, a_eq_b} == 3'b010) |
                      ({a_gt_b, a_lt_b, a_eq_b} == 3'b001);
    assign w_last   = (r_idx == '0);
    assign w_bit    = ONE << r_idx;
    assign w_kept   = a_lt_b ? (r_trial & ~w_bit) : r_trial;
    assign w_upd    = w_last ? w_kept : (w_kept | (w_bit >> 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_PROBE;
            end
            S_PROBE: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_sample && (!w_onehot || a_eq_b || w_last)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = w_start ? S_PROBE : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (r_state == S_PROBE);
        done = (r_state == S_DONE);
    end

    assign trial  = r_trial;
    assign result = r_result;
    assign found  = r_found;
    assign err    = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trial  <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_wait   <= '0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_start) begin
            r_trial  <= ONE << MSB_IDX;
            r_idx    <= MSB_IDX;
            r_wait   <= LAT;
            r_result <= '0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
        end else if (r_state == S_PROBE) begin
            if (abort) begin
                r_trial <= '0;
            end else if (r_wait != '0) begin
                r_wait <= r_wait - CW'(1);
            end else if (!w_onehot) begin
                r_result <= r_trial;
                r_err    <= 1'b1;
            end else if (a_eq_b) begin
                r_result <= r_trial;
                r_found  <= 1'b1;
            end else begin
                r_trial <= w_upd;
                if (w_last) begin
                    r_result <= w_upd;
                end else begin
                    r_idx  <= r_idx - IW'(1);
                    r_wait <= LAT;
                end
            end
        end
    end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl: scoreboard bench for sar_search_ctrl.
// Instance 0 uses a combinational comparator, instance 1 a two-cycle-latency one.
module tb_sar_search_ctrl;
    typedef struct {
        int         done_edge;
        logic [3:0] res;
        logic       fnd;
        logic       er;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic       st0 = 1'b0, ab0 = 1'b0, bad0 = 1'b0;
    logic [3:0] tg0 = 4'd0;
    logic       gt0, lt0, eq0, busy0, done0, found0, err0;
    logic [3:0] tr0, res0;

    logic       st1 = 1'b0, ab1 = 1'b0, gl1 = 1'b0;
    logic [3:0] tg1 = 4'd0;
    logic       gt1, lt1, eq1, busy1, done1, found1, err1, w_gl;
    logic [3:0] tr1, res1;

    int edge_n   = 0;
    int st1_edge = 0;
    int checks   = 0;
    int failures = 0;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [3:0] t0[$];
    logic [3:0] t1[$];

    sar_search_ctrl #(.WIDTH(4), .CMP_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .abort(ab0),
        .a_gt_b(gt0), .a_lt_b(lt0), .a_eq_b(eq0),
        .trial(tr0), .busy(busy0), .done(done0),
        .result(res0), .found(found0), .err(err0)
    );

    sar_search_ctrl #(.WIDTH(4), .CMP_LAT(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .abort(ab1),
        .a_gt_b(gt1), .a_lt_b(lt1), .a_eq_b(eq1),
        .trial(tr1), .busy(busy1), .done(done1),
        .result(res1), .found(found1), .err(err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    always_comb begin
        gt0 = bad0 | (tg0 > tr0);
        lt0 = bad0 | (tg0 < tr0);
        eq0 = ~bad0 & (tg0 == tr0);
    end

    // garbage flags on every cycle except the one ahead of a sampling edge
    always_comb begin
        w_gl = gl1 && (((edge_n - st1_edge) % 3) != 2);
        gt1  = (tg1 > tr1) ^ w_gl;
        lt1  = (tg1 < tr1) ^ w_gl;
        eq1  = (tg1 == tr1) ^ w_gl;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (busy0) begin
                if (t0.size() == 0) chk("trial0_extra", busy0, 0);
                else chk("trial0", tr0, t0.pop_front());
            end
            if (done0) begin
                if (q0.size() == 0) begin
                    chk("done0_unexpected", done0, 0);
                end else begin
                    e = q0.pop_front();
                    chk("done0_edge", edge_n, e.done_edge);
                    chk("result0", res0, e.res);
                    chk("found0", found0, e.fnd);
                    chk("err0", err0, e.er);
                end
            end
            if (busy1) begin
                if (t1.size() == 0) chk("trial1_extra", busy1, 0);
                else chk("trial1", tr1, t1.pop_front());
            end
            if (done1) begin
                if (q1.size() == 0) begin
                    chk("done1_unexpected", done1, 0);
                end else begin
                    e = q1.pop_front();
                    chk("done1_edge", edge_n, e.done_edge);
                    chk("result1", res1, e.res);
                    chk("found1", found1, e.fnd);
                    chk("err1", err1, e.er);
                end
            end
        end
    end

    // tv holds up to four trials, first in the top nibble; lat<0 means no done
    task automatic launch(input int inst, input logic [3:0] tgt,
                          input logic [15:0] tv, input int n, input int rep,
                          input logic [3:0] res, input logic fnd,
                          input logic er, input int lat);
        exp_t e;
        e.done_edge = edge_n + 1 + lat;
        e.res       = res;
        e.fnd       = fnd;
        e.er        = er;
        for (int k = 0; k < n; k++) begin
            for (int r = 0; r < rep; r++) begin
                if (inst == 0) t0.push_back(tv[15-4*k -: 4]);
                else t1.push_back(tv[15-4*k -: 4]);
            end
        end
        if (inst == 0) begin
            if (lat >= 0) q0.push_back(e);
            tg0 = tgt;
            st0 = 1'b1;
        end else begin
            if (lat >= 0) q1.push_back(e);
            st1_edge = edge_n + 1;
            tg1 = tgt;
            st1 = 1'b1;
        end
        @(negedge clk);
        st0 = 1'b0;
        st1 = 1'b0;
    endtask

    task automatic wait_q(input int inst);
        int sz;
        for (int k = 0; k < 80; k++) begin
            sz = (inst == 0) ? q0.size() : q1.size();
            if (sz == 0) return;
            @(negedge clk);
        end
        sz = (inst == 0) ? q0.size() : q1.size();
        chk((inst == 0) ? "timeout0" : "timeout1", sz, 0);
        if (inst == 0) begin
            q0.delete();
            t0.delete();
        end else begin
            q1.delete();
            t1.delete();
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_trial", tr0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_result", res0, 0);
        chk("rst_found", found0, 0);
        chk("rst_err", err0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        launch(0, 4'b1011, 16'h8CAB, 4, 1, 4'b1011, 1'b1, 1'b0, 4);
        wait_q(0);
        repeat (3) @(negedge clk);
        chk("hold_result", res0, 4'b1011);
        chk("hold_found", found0, 1);

        launch(0, 4'b0000, 16'h8421, 4, 1, 4'b0000, 1'b0, 1'b0, 4);
        wait_q(0);
        launch(0, 4'b1000, 16'h8000, 1, 1, 4'b1000, 1'b1, 1'b0, 1);
        wait_q(0);
        launch(0, 4'b1111, 16'h8CEF, 4, 1, 4'b1111, 1'b1, 1'b0, 4);
        wait_q(0);
        launch(0, 4'b0111, 16'h8467, 4, 1, 4'b0111, 1'b1, 1'b0, 4);
        wait_q(0);

        bad0 = 1'b1;
        launch(0, 4'b1011, 16'h8000, 1, 1, 4'b1000, 1'b0, 1'b1, 1);
        wait_q(0);
        bad0 = 1'b0;
        @(negedge clk);
        chk("err_held", err0, 1);
        launch(0, 4'b1011, 16'h8CAB, 4, 1, 4'b1011, 1'b1, 1'b0, 4);
        chk("err_cleared", err0, 0);
        wait_q(0);

        launch(0, 4'b1011, 16'h8C00, 2, 1, 4'b0000, 1'b0, 1'b0, -1);
        @(negedge clk);
        ab0 = 1'b1;
        @(negedge clk);
        ab0 = 1'b0;
        chk("abort_busy", busy0, 0);
        chk("abort_trial", tr0, 0);
        chk("abort_done", done0, 0);
        chk("abort_result", res0, 0);
        chk("abort_found", found0, 0);
        repeat (4) @(negedge clk);

        st0 = 1'b1;
        ab0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        ab0 = 1'b0;
        chk("startabort_busy", busy0, 0);
        @(negedge clk);
        chk("startabort_busy2", busy0, 0);
        chk("startabort_trial", tr0, 0);

        launch(0, 4'b1000, 16'h8000, 1, 1, 4'b1000, 1'b1, 1'b0, 1);
        @(negedge clk);
        launch(0, 4'b0011, 16'h8423, 4, 1, 4'b0011, 1'b1, 1'b0, 4);
        wait_q(0);

        launch(1, 4'b0110, 16'h8460, 3, 3, 4'b0110, 1'b1, 1'b0, 9);
        wait_q(1);
        gl1 = 1'b1;
        launch(1, 4'b0000, 16'h8421, 4, 3, 4'b0000, 1'b0, 1'b0, 12);
        wait_q(1);
        launch(1, 4'b0110, 16'h8460, 3, 3, 4'b0110, 1'b1, 1'b0, 9);
        wait_q(1);
        gl1 = 1'b0;
        repeat (2) @(negedge clk);

        launch(0, 4'b1111, 16'h8000, 1, 1, 4'b0000, 1'b0, 1'b0, -1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_trial", tr0, 0);
        chk("midrst_busy", busy0, 0);
        chk("midrst_done", done0, 0);
        chk("midrst_result1", res1, 0);
        chk("midrst_found1", found1, 0);
        chk("midrst_err", err0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        chk("left_t0", t0.size(), 0);
        chk("left_t1", t1.size(), 0);
        chk("left_q0", q0.size(), 0);
        chk("left_q1", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
